// File: rtl/sprite_grid_mover_pkg.sv
// sprite_grid_mover_pkg: shared FSM states, button bit indices and screen limits
package sprite_grid_mover_pkg;
  typedef enum logic {IDLE, APPLY} state_t;
  localparam int U = 0;
  localparam int D = 1;
  localparam int L = 2;
  localparam int R = 3;
  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MAX = 479;
endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test: tests one pixel against one sprite window and returns its local dx/dy
module sprite_hit_test #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int HALF = 10,
  parameter int DW = $clog2(2 * HALF)
) (
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic           pix_valid,
  output logic           in_win,
  output logic [DW-1:0]  dx,
  output logic [DW-1:0]  dy
);
  logic [X_W:0] ex;
  logic [Y_W:0] ey;
  always_comb begin
    ex = {1'b0, pix_x} - {1'b0, cx} + (X_W+1)'(HALF);
    ey = {1'b0, pix_y} - {1'b0, cy} + (Y_W+1)'(HALF);
    in_win = pix_valid && ex < (X_W+1)'(2 * HALF) && ey < (Y_W+1)'(2 * HALF);
    dx = ex[DW-1:0];
    dy = ey[DW-1:0];
  end
endmodule

// File: rtl/sprite_grid_mover.sv
// sprite_grid_mover: frame-synchronous clamped grid moves for tokens plus pipelined per-pixel hit resolve
module sprite_grid_mover
  import sprite_grid_mover_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int GRID_STEP = 20,
  parameter int HALF = 10,
  parameter int X_MAX = SCR_X_MAX,
  parameter int Y_MAX = SCR_Y_MAX,
  parameter logic [NUM_SPRITES*X_W-1:0] INIT_X = {10'd320, 10'd510, 10'd400, 10'd95},
  parameter logic [NUM_SPRITES*Y_W-1:0] INIT_Y = {9'd200, 9'd85, 9'd400, 9'd85},
  parameter int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1,
  parameter int OW = $clog2(4 * HALF * HALF),
  parameter int DW = $clog2(2 * HALF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       btn_u,
  input  logic                       btn_d,
  input  logic                       btn_l,
  input  logic                       btn_r,
  input  logic [NUM_SPRITES-1:0]     sel,
  input  logic [X_W-1:0]             pix_x,
  input  logic [Y_W-1:0]             pix_y,
  input  logic                       pix_valid,
  output logic                       hit,
  output logic [IW-1:0]              hit_id,
  output logic [OW-1:0]              hit_off,
  output logic [NUM_SPRITES*X_W-1:0] pos_x,
  output logic [NUM_SPRITES*Y_W-1:0] pos_y,
  output logic                       busy
);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] btn, prev_q, pending_q, pending_d, req_q, req_d;
  logic busy_q, busy_d, snap, mv_u, mv_d, mv_l, mv_r;
  logic [NUM_SPRITES-1:0] act, win, win_q;
  logic [X_W-1:0] px_q [NUM_SPRITES];
  logic [X_W-1:0] px_d [NUM_SPRITES];
  logic [Y_W-1:0] py_q [NUM_SPRITES];
  logic [Y_W-1:0] py_d [NUM_SPRITES];
  logic [DW-1:0] dx [NUM_SPRITES];
  logic [DW-1:0] dy [NUM_SPRITES];
  logic [DW-1:0] dx_q [NUM_SPRITES];
  logic [DW-1:0] dy_q [NUM_SPRITES];
  logic hit_q, hit_d;
  logic [IW-1:0] id_q, id_d;
  logic [OW-1:0] off_q, off_d;
  assign btn = {btn_r, btn_l, btn_d, btn_u};
  always_comb begin
    snap = state_q == IDLE && frame_tick && |pending_q;
    pending_d = (snap ? 4'b0 : pending_q) | (btn & ~prev_q);
    req_d = snap ? pending_q : req_q;
    state_d = snap ? APPLY : (state_q == APPLY && idx_q == IW'(NUM_SPRITES - 1)) ? IDLE : state_q;
    idx_d = state_q == APPLY ? idx_q + 1'b1 : '0;
    busy_d = state_d == APPLY;
    mv_u = req_q[U] & ~req_q[D];
    mv_d = req_q[D] & ~req_q[U];
    mv_l = req_q[L] & ~req_q[R];
    mv_r = req_q[R] & ~req_q[L];
    for (int i = 0; i < NUM_SPRITES; i++) begin
      act[i] = state_q == APPLY && sel[i] && idx_q == IW'(i);
      px_d[i] = !act[i] ? px_q[i] :
                (mv_r && {1'b0, px_q[i]} + (X_W+1)'(GRID_STEP) <= (X_W+1)'(X_MAX - HALF + 1)) ? px_q[i] + X_W'(GRID_STEP) :
                (mv_l && {1'b0, px_q[i]} >= (X_W+1)'(HALF + GRID_STEP)) ? px_q[i] - X_W'(GRID_STEP) : px_q[i];
      py_d[i] = !act[i] ? py_q[i] :
                (mv_d && {1'b0, py_q[i]} + (Y_W+1)'(GRID_STEP) <= (Y_W+1)'(Y_MAX - HALF + 1)) ? py_q[i] + Y_W'(GRID_STEP) :
                (mv_u && {1'b0, py_q[i]} >= (Y_W+1)'(HALF + GRID_STEP)) ? py_q[i] - Y_W'(GRID_STEP) : py_q[i];
      pos_x[i*X_W +: X_W] = px_q[i];
      pos_y[i*Y_W +: Y_W] = py_q[i];
    end
  end
  always_comb begin
    hit_d = |win_q;
    id_d = '0;
    off_d = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      id_d = win_q[i] ? IW'(i) : id_d;
      off_d = win_q[i] ? OW'(dy_q[i]) * OW'(2 * HALF) + OW'(dx_q[i]) : off_d;
    end
  end
  genvar g;
  for (g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_test #(.X_W(X_W), .Y_W(Y_W), .HALF(HALF), .DW(DW)) u_hit (
      .cx(px_q[g]), .cy(py_q[g]), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .in_win(win[g]), .dx(dx[g]), .dy(dy[g])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      prev_q <= '0;
      pending_q <= '0;
      req_q <= '0;
      busy_q <= 1'b0;
      win_q <= '0;
      hit_q <= 1'b0;
      id_q <= '0;
      off_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px_q[i] <= INIT_X[i*X_W +: X_W];
        py_q[i] <= INIT_Y[i*Y_W +: Y_W];
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      prev_q <= btn;
      pending_q <= pending_d;
      req_q <= req_d;
      busy_q <= busy_d;
      win_q <= win;
      hit_q <= hit_d;
      id_q <= id_d;
      off_q <= off_d;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
        dx_q[i] <= dx[i];
        dy_q[i] <= dy[i];
      end
    end
  end
  assign hit = hit_q;
  assign hit_id = id_q;
  assign hit_off = off_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sprite_grid_mover.sv
// tb_sprite_grid_mover: directed checks of moves, clamping, request timing, reset and hit pipeline
module tb_sprite_grid_mover;
  localparam logic [3:0] BU = 4'b0001, BD = 4'b0010, BL = 4'b0100, BR = 4'b1000;
  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [3:0] sel = 4'b0;
  logic [9:0] pix_x = '0;
  logic [8:0] pix_y = '0;
  logic pix_valid = 1'b0;
  logic hit, busy;
  logic [1:0] hit_id;
  logic [8:0] hit_off;
  logic [39:0] pos_x;
  logic [35:0] pos_y;
  int n_chk = 0, n_bad = 0;
  int tv [11][6];
  sprite_grid_mover dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .sel(sel),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .hit(hit), .hit_id(hit_id), .hit_off(hit_off),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [39:0] px4(int a0, int a1, int a2, int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction
  function automatic logic [35:0] py4(int a0, int a1, int a2, int a3);
    return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_btn(input logic [3:0] m);
    {btn_r, btn_l, btn_d, btn_u} = m;
  endtask
  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(6);
  endtask
  task automatic press(input logic [3:0] m, input logic [3:0] s);
    sel = s;
    set_btn(m);
    cyc(1);
    set_btn(4'b0);
    cyc(1);
    frame();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b1;
    cyc(2);
    frame_tick = 1'b0;
    reset = 1'b0;
    cyc(1);
  endtask
  initial begin
    do_reset();
    chk("rst_x", pos_x, px4(95, 400, 510, 320));
    chk("rst_y", pos_y, py4(85, 400, 85, 200));
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_off", hit_off, 0);
    sel = 4'b0010;
    btn_r = 1'b1;
    cyc(1);
    repeat (50) frame();
    btn_r = 1'b0;
    chk("held_x", pos_x, px4(95, 420, 510, 320));
    chk("held_y", pos_y, py4(85, 400, 85, 200));
    for (int k = 1; k <= 4; k++) begin
      press(BU, 4'b0001);
      chk("up_y0", pos_y[8:0], k <= 3 ? 85 - 20 * k : 25);
    end
    press(BD, 4'b0001);
    chk("down_y0", pos_y[8:0], 45);
    for (int k = 1; k <= 7; k++) begin
      press(BR, 4'b0100);
      chk("right_x2", pos_x[29:20], k <= 6 ? 510 + 20 * k : 630);
    end
    for (int k = 1; k <= 32; k++) begin
      press(BL, 4'b0100);
      chk("left_x2", pos_x[29:20], k <= 31 ? 630 - 20 * k : 10);
    end
    press(BU | BD, 4'b1111);
    chk("ud_y", pos_y, py4(45, 400, 85, 200));
    chk("ud_x", pos_x, px4(95, 420, 10, 320));
    press(BL | BU, 4'b1011);
    chk("diag_x", pos_x, px4(75, 400, 10, 300));
    chk("diag_y", pos_y, py4(25, 380, 85, 180));
    press(BL | BR | BD, 4'b0001);
    chk("lrd_x", pos_x, px4(75, 400, 10, 300));
    chk("lrd_y", pos_y, py4(45, 380, 85, 180));
    sel = 4'b0;
    press(BR, 4'b0000);
    chk("sel0_x", pos_x, px4(75, 400, 10, 300));
    do_reset();
    repeat (4) press(BL | BU, 4'b0010);
    repeat (6) press(BU, 4'b0010);
    chk("ovl_x", pos_x, px4(95, 320, 510, 320));
    chk("ovl_y", pos_y, py4(85, 200, 85, 200));
    pix_x = 10'd310;
    pix_y = 9'd190;
    pix_valid = 1'b1;
    cyc(1);
    chk("lat1_hit", hit, 0);
    cyc(1);
    chk("lat2_hit", hit, 1);
    tv = '{'{310, 190, 1, 1, 1, 0}, '{329, 209, 1, 1, 1, 399}, '{330, 200, 1, 0, 0, 0},
           '{320, 210, 1, 0, 0, 0}, '{309, 200, 1, 0, 0, 0}, '{320, 200, 0, 0, 0, 0},
           '{320, 200, 1, 1, 1, 210}, '{100, 90, 1, 1, 0, 315}, '{85, 75, 1, 1, 0, 0},
           '{0, 0, 1, 0, 0, 0}, '{519, 94, 1, 1, 2, 399}};
    for (int i = 0; i < 11; i++) begin
      pix_x = 10'(tv[i][0]);
      pix_y = 9'(tv[i][1]);
      pix_valid = tv[i][2] != 0;
      cyc(2);
      chk($sformatf("hit%0d", i), hit, 64'(tv[i][3]));
      chk($sformatf("id%0d", i), hit_id, 64'(tv[i][4]));
      chk($sformatf("off%0d", i), hit_off, 64'(tv[i][5]));
    end
    pix_valid = 1'b0;
    do_reset();
    sel = 4'b0001;
    btn_d = 1'b1;
    cyc(1);
    btn_d = 1'b0;
    cyc(1);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("apply_busy", busy, 1);
    btn_r = 1'b1;
    cyc(1);
    btn_r = 1'b0;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(5);
    chk("idle_busy", busy, 0);
    chk("during_x0", pos_x[9:0], 95);
    chk("during_y0", pos_y[8:0], 105);
    frame();
    chk("later_x0", pos_x[9:0], 115);
    btn_u = 1'b1;
    cyc(1);
    btn_u = 1'b0;
    cyc(1);
    frame_tick = 1'b1;
    btn_d = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    btn_d = 1'b0;
    cyc(6);
    chk("snap_y0", pos_y[8:0], 85);
    frame();
    chk("kept_y0", pos_y[8:0], 105);
    sel = 4'b1111;
    btn_u = 1'b1;
    cyc(1);
    btn_u = 1'b0;
    cyc(1);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);
    chk("mid_y", pos_y, py4(85, 380, 85, 200));
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mrst_x", pos_x, px4(95, 400, 510, 320));
    chk("mrst_y", pos_y, py4(85, 400, 85, 200));
    chk("mrst_busy", busy, 0);
    frame();
    chk("post_y", pos_y, py4(85, 400, 85, 200));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
